// File: rtl/round_ctrl.sv
// Game-round controller: issues the ready request, captures the round target,
// judges the answer against its smallest prime factor and sequences result states.
module round_ctrl #(
  parameter int unsigned OK_TIMEOUT    = 100_000_000,
  parameter int unsigned ANSWER_CYCLES = 500_000_000,
  parameter int unsigned RESULT_CYCLES = 100_000_000,
  parameter int unsigned WIN_SCORE     = 5,
  parameter int unsigned LOSE_SCORE    = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       OK,
  input  logic [3:0] NUM,
  input  logic       ANS_VALID,
  input  logic [3:0] ANS,
  output logic       READY_1P,
  output logic [3:0] STATE,
  output logic [3:0] TARGET,
  output logic [3:0] SCORE,
  output logic [3:0] MISS
);

  // One down-counter covers all three waits, so it is sized for the longest.
  localparam int unsigned MAX_AB  = (OK_TIMEOUT > ANSWER_CYCLES) ? OK_TIMEOUT : ANSWER_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > RESULT_CYCLES) ? MAX_AB : RESULT_CYCLES;
  localparam int          TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0] OK_LOAD  = TW'(OK_TIMEOUT - 1);
  localparam logic [TW-1:0] ANS_LOAD = TW'(ANSWER_CYCLES - 1);
  localparam logic [TW-1:0] RES_LOAD = TW'(RESULT_CYCLES - 1);
  localparam logic [TW-1:0] ONE      = TW'(1);
  localparam logic [3:0]    WIN_CNT  = 4'(WIN_SCORE);
  localparam logic [3:0]    LOSE_CNT = 4'(LOSE_SCORE);

  typedef enum logic [3:0] {
    S_IDLE    = 4'b0000,
    S_WAIT_OK = 4'b0001,
    S_PLAY    = 4'b0010,
    S_DRAW    = 4'b0110,
    S_GOOD    = 4'b1000,
    S_OUCH    = 4'b1001,
    S_WIN     = 4'b1010,
    S_LOSE    = 4'b1011
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    target, target_n;
  logic [3:0]    score, score_n;
  logic [3:0]    miss, miss_n;
  logic          ready, ready_n;
  logic [3:0]    score_inc, miss_inc;

  function automatic logic [3:0] smallest_prime(input logic [3:0] t);
    case (t)
      4'd2, 4'd4, 4'd6, 4'd8: smallest_prime = 4'd2;
      4'd3, 4'd9:             smallest_prime = 4'd3;
      4'd5:                   smallest_prime = 4'd5;
      4'd7:                   smallest_prime = 4'd7;
      default:                smallest_prime = 4'd0;
    endcase
  endfunction

  assign score_inc = (score == 4'd15) ? score : score + 4'd1;
  assign miss_inc  = (miss == 4'd15) ? miss : miss + 4'd1;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    target_n = target;
    score_n  = score;
    miss_n   = miss;
    ready_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          ready_n = 1'b1;
          state_n = S_WAIT_OK;
          timer_n = OK_LOAD;
        end
      end
      S_WAIT_OK: begin
        if (OK) begin
          target_n = NUM;
          state_n  = S_PLAY;
          timer_n  = ANS_LOAD;
        end else if (timer == '0) begin
          state_n = S_DRAW;
          timer_n = RES_LOAD;
        end else begin
          timer_n = timer - ONE;
        end
      end
      S_PLAY: begin
        // An answer on the expiry cycle wins over the timeout.
        if (ANS_VALID && ANS == smallest_prime(target)) begin
          score_n = score_inc;
          state_n = (score_inc == WIN_CNT) ? S_WIN : S_GOOD;
          timer_n = RES_LOAD;
        end else if (ANS_VALID || timer == '0) begin
          miss_n  = miss_inc;
          state_n = (miss_inc == LOSE_CNT) ? S_LOSE : S_OUCH;
          timer_n = RES_LOAD;
        end else begin
          timer_n = timer - ONE;
        end
      end
      S_DRAW, S_GOOD, S_OUCH, S_WIN, S_LOSE: begin
        if (timer == '0) begin
          state_n = S_IDLE;
          timer_n = '0;
          if (state == S_WIN || state == S_LOSE) begin
            score_n = 4'd0;
            miss_n  = 4'd0;
          end
        end else begin
          timer_n = timer - ONE;
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all update together on the edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      timer  <= '0;
      target <= 4'd0;
      score  <= 4'd0;
      miss   <= 4'd0;
      ready  <= 1'b0;
    end else begin
      state  <= state_n;
      timer  <= timer_n;
      target <= target_n;
      score  <= score_n;
      miss   <= miss_n;
      ready  <= ready_n;
    end
  end

  assign READY_1P = ready;
  assign STATE    = state;
  assign TARGET   = target;
  assign SCORE    = score;
  assign MISS     = miss;

endmodule

// File: tb/tb_round_ctrl.sv
// Scoreboard bench for round_ctrl: each driven cycle queues its expected outputs,
// which are popped and compared one time unit after the clock edge.
module tb_round_ctrl;

  localparam int OKT = 16, ANSC = 20, RESC = 4, WINS = 3, LOSES = 2;

  localparam logic [3:0] C_IDLE = 4'b0000, C_WAIT = 4'b0001, C_PLAY = 4'b0010,
                         C_DRAW = 4'b0110, C_GOOD = 4'b1000, C_OUCH = 4'b1001,
                         C_WIN  = 4'b1010, C_LOSE = 4'b1011;

  logic       CLK = 1'b0, RST_N = 1'b0;
  logic       START = 1'b0, OK = 1'b0, ANS_VALID = 1'b0;
  logic [3:0] NUM = 4'd0, ANS = 4'd0;
  logic       READY_1P;
  logic [3:0] STATE, TARGET, SCORE, MISS;

  round_ctrl #(
    .OK_TIMEOUT(OKT), .ANSWER_CYCLES(ANSC), .RESULT_CYCLES(RESC),
    .WIN_SCORE(WINS), .LOSE_SCORE(LOSES)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .OK(OK), .NUM(NUM),
    .ANS_VALID(ANS_VALID), .ANS(ANS), .READY_1P(READY_1P),
    .STATE(STATE), .TARGET(TARGET), .SCORE(SCORE), .MISS(MISS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [3:0] state, target, score, miss;
    logic       ready;
  } exp_t;

  exp_t       sb[$];
  int         n_vec = 0, n_err = 0;
  logic [3:0] tg_e = 4'd0, sc_e = 4'd0, ms_e = 4'd0;
  logic [3:0] spf_ref [16] = '{4'd0, 4'd0, 4'd2, 4'd3, 4'd2, 4'd5, 4'd2, 4'd7,
                               4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".state"},  32'(STATE),    32'd0);
    check({tag, ".ready"},  32'(READY_1P), 32'd0);
    check({tag, ".target"}, 32'(TARGET),   32'd0);
    check({tag, ".score"},  32'(SCORE),    32'd0);
    check({tag, ".miss"},   32'(MISS),     32'd0);
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic tick(input logic s, input logic o, input logic [3:0] n,
                      input logic av, input logic [3:0] a,
                      input string tag, input logic [3:0] st, input logic rd);
    exp_t e;
    START = s; OK = o; NUM = n; ANS_VALID = av; ANS = a;
    e.tag = tag; e.state = st; e.target = tg_e; e.score = sc_e; e.miss = ms_e; e.ready = rd;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    START = 1'b0; OK = 1'b0; ANS_VALID = 1'b0;
    e = sb.pop_front();
    check({e.tag, ".state"},  32'(STATE),    32'(e.state));
    check({e.tag, ".ready"},  32'(READY_1P), 32'(e.ready));
    check({e.tag, ".target"}, 32'(TARGET),   32'(e.target));
    check({e.tag, ".score"},  32'(SCORE),    32'(e.score));
    check({e.tag, ".miss"},   32'(MISS),     32'(e.miss));
  endtask

  // Idle cycles; OK and ANS_VALID are pulsed and must be ignored.
  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 4'd7, 1'b1, 4'd7, {name, ".idle"}, C_IDLE, 1'b0);
  endtask

  task automatic no_ok_round(input string name);
    tick(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, {name, ".start"}, C_WAIT, 1'b1);
    for (int i = 1; i < OKT; i++) tick(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, {name, ".wait"}, C_WAIT, 1'b0);
    for (int i = 0; i < RESC; i++) tick(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, {name, ".draw"}, C_DRAW, 1'b0);
    tick(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, {name, ".done"}, C_IDLE, 1'b0);
  endtask

  // ans_delay: cycle within PLAY (1..ANSC) carrying the answer; 0 means no answer.
  task automatic play_round(input logic [3:0] num, input int ok_delay, input int ans_delay,
                            input logic [3:0] ans, input logic poke, input string name);
    logic [3:0] res;
    logic       answered;
    int         nplay;
    tick(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, {name, ".start"}, C_WAIT, 1'b1);
    for (int i = 0; i < ok_delay; i++)
      tick(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, {name, ".wait"}, C_WAIT, 1'b0);
    tg_e = num;
    tick(1'b0, 1'b1, num, 1'b0, 4'd0, {name, ".ok"}, C_PLAY, 1'b0);
    answered = (ans_delay > 0);
    nplay    = answered ? ans_delay - 1 : ANSC - 1;
    for (int i = 0; i < nplay; i++)
      tick(poke, poke, 4'd9, 1'b0, 4'd0, {name, ".play"}, C_PLAY, 1'b0);
    if (answered && ans == spf_ref[num]) begin
      sc_e = (sc_e == 4'd15) ? 4'd15 : sc_e + 4'd1;
      res  = (sc_e == 4'(WINS)) ? C_WIN : C_GOOD;
    end else begin
      ms_e = (ms_e == 4'd15) ? 4'd15 : ms_e + 4'd1;
      res  = (ms_e == 4'(LOSES)) ? C_LOSE : C_OUCH;
    end
    tick(1'b0, 1'b0, 4'd0, answered, ans, {name, ".judge"}, res, 1'b0);
    for (int i = 1; i < RESC; i++)
      tick(poke, poke, 4'd9, poke, spf_ref[num], {name, ".hold"}, res, 1'b0);
    if (res == C_WIN || res == C_LOSE) begin
      sc_e = 4'd0;
      ms_e = 4'd0;
    end
    tick(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, {name, ".done"}, C_IDLE, 1'b0);
  endtask

  initial begin
    #2;
    check_zero("reset");
    #10 RST_N = 1'b1;
    idle(2, "post_reset");

    no_ok_round("no_ok");
    play_round(4'd6, 2, 1, 4'd2, 1'b0, "normal");
    idle(1, "between");
    play_round(4'd9, 0, 2, 4'd9, 1'b0, "wrong");
    play_round(4'd5, 0, 0, 4'd0, 1'b0, "timeout");
    play_round(4'd1, 0, 1, 4'd0, 1'b0, "win1");
    play_round(4'd7, 0, 5, 4'd7, 1'b0, "win2");
    play_round(4'd8, 0, 1, 4'd2, 1'b0, "win3");
    play_round(4'd4, 0, ANSC, 4'd2, 1'b1, "collide");

    // Reset asserted between clock edges in the middle of PLAY.
    tick(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, "mid.start", C_WAIT, 1'b1);
    tg_e = 4'd3;
    tick(1'b0, 1'b1, 4'd3, 1'b0, 4'd0, "mid.ok", C_PLAY, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, "mid.play", C_PLAY, 1'b0);
    #2 RST_N = 1'b0;
    #1 check_zero("mid.reset");
    #2 RST_N = 1'b1;
    tg_e = 4'd0; sc_e = 4'd0; ms_e = 4'd0;
    idle(1, "after_reset");
    play_round(4'd2, 0, 3, 4'd2, 1'b0, "restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
